// File: rtl/jtshouse_scr_sched.sv
// Per-scanline scroll layer scheduler: latches the layer registers at line start and
// issues one render request per enabled layer in priority order. Optional: JTSHOUSE_SCHED_FLIP_EN.
module jtshouse_scr_sched #(
  parameter logic [8:0] HOFFSET = 9'd0,
  parameter logic [8:0] VOFFSET = 9'd0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        hs,
  input  logic [8:0]  vrender,
  input  logic [63:0] hscr,
  input  logic [63:0] vscr,
  input  logic [5:0]  enb,
  input  logic [17:0] prio,
  input  logic [17:0] pal,
`ifdef JTSHOUSE_SCHED_FLIP_EN
  input  logic        flip,
`endif
  output logic        req,
  input  logic        ack,
  output logic [2:0]  layer,
  output logic [8:0]  row,
  output logic [8:0]  hpos,
  output logic [2:0]  lpal,
  output logic [2:0]  lprio,
  output logic        busy,
  output logic        line_done,
  output logic        overrun
);

  // Handshake: req rises with the request fields and both hold until ack is sampled
  // high on a clock edge; ack while req is low has no effect.
  typedef enum logic [1:0] {IDLE, SCAN, REQ} state_t;

  state_t state_q, state_d;

  logic            hs_l_q;
  logic [5:0]      enb_q, enb_d;
  logic [5:0][2:0] prio_q, prio_d;
  logic [5:0][2:0] pal_q, pal_d;
  logic [3:0][8:0] hscr_q, hscr_d;
  logic [3:0][8:0] vscr_q, vscr_d;
  logic [8:0]      vrender_q, vrender_d;
  logic [2:0]      p_q, p_d, l_q, l_d;
  logic            req_q, req_d;
  logic [2:0]      layer_q, layer_d, lpal_q, lpal_d, lprio_q, lprio_d;
  logic [8:0]      row_q, row_d, hpos_q, hpos_d;
  logic            line_done_q, line_done_d;
  logic            overrun_q, overrun_d;
  logic            flip_q;

  logic       start, match, last_slot;
  logic [8:0] row_calc, hpos_calc;
  logic       unused_scr;

  // Only the low 9 bits of each 16-bit scroll word address the tilemap.
  assign unused_scr = ^{hscr[15:9], hscr[31:25], hscr[47:41], hscr[63:57],
                        vscr[15:9], vscr[31:25], vscr[47:41], vscr[63:57]};

`ifdef JTSHOUSE_SCHED_FLIP_EN
  always_ff @(posedge clk) begin
    if (rst)        flip_q <= 1'b0;
    else if (start) flip_q <= flip;
  end
`else
  assign flip_q = 1'b0;
`endif

  assign start     = hs & ~hs_l_q;
  assign match     = enb_q[l_q] && (prio_q[l_q] == p_q);
  assign last_slot = (p_q == 3'd7) && (l_q == 3'd5);

  always_comb begin
    row_calc  = vrender_q;
    hpos_calc = 9'd0;
    if (l_q < 3'd4) begin
      row_calc  = vrender_q + vscr_q[l_q[1:0]] + VOFFSET;
      hpos_calc = hscr_q[l_q[1:0]] + HOFFSET;
    end
    if (flip_q) begin
      row_calc  = ~row_calc;
      hpos_calc = 9'd0 - hpos_calc;
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (start) state_d = SCAN;
      SCAN: begin
        if (start)          state_d = SCAN;
        else if (match)     state_d = REQ;
        else if (last_slot) state_d = IDLE;
      end
      REQ: begin
        if (start)    state_d = SCAN;
        else if (ack) state_d = last_slot ? IDLE : SCAN;
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs and slot walk
  always_comb begin
    enb_d       = enb_q;
    prio_d      = prio_q;
    pal_d       = pal_q;
    hscr_d      = hscr_q;
    vscr_d      = vscr_q;
    vrender_d   = vrender_q;
    p_d         = p_q;
    l_d         = l_q;
    req_d       = req_q;
    layer_d     = layer_q;
    row_d       = row_q;
    hpos_d      = hpos_q;
    lpal_d      = lpal_q;
    lprio_d     = lprio_q;
    line_done_d = 1'b0;
    overrun_d   = 1'b0;
    if (start) begin
      enb_d     = enb;
      prio_d    = prio;
      pal_d     = pal;
      vrender_d = vrender;
      for (int n = 0; n < 4; n++) begin
        hscr_d[n] = hscr[n*16 +: 9];
        vscr_d[n] = vscr[n*16 +: 9];
      end
      p_d       = 3'd0;
      l_d       = 3'd0;
      req_d     = 1'b0;
      overrun_d = (state_q != IDLE);
    end else begin
      case (state_q)
        SCAN: begin
          if (match) begin
            req_d   = 1'b1;
            layer_d = l_q;
            row_d   = row_calc;
            hpos_d  = hpos_calc;
            lpal_d  = pal_q[l_q];
            lprio_d = p_q;
          end else begin
            l_d         = (l_q == 3'd5) ? 3'd0 : l_q + 3'd1;
            p_d         = (l_q == 3'd5) ? p_q + 3'd1 : p_q;
            line_done_d = last_slot;
          end
        end
        REQ: begin
          if (ack) begin
            req_d       = 1'b0;
            l_d         = (l_q == 3'd5) ? 3'd0 : l_q + 3'd1;
            p_d         = (l_q == 3'd5) ? p_q + 3'd1 : p_q;
            line_done_d = last_slot;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hs_l_q      <= 1'b0;
      enb_q       <= '0;
      prio_q      <= '0;
      pal_q       <= '0;
      hscr_q      <= '0;
      vscr_q      <= '0;
      vrender_q   <= '0;
      p_q         <= '0;
      l_q         <= '0;
      req_q       <= 1'b0;
      layer_q     <= '0;
      row_q       <= '0;
      hpos_q      <= '0;
      lpal_q      <= '0;
      lprio_q     <= '0;
      line_done_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      hs_l_q      <= hs;
      enb_q       <= enb_d;
      prio_q      <= prio_d;
      pal_q       <= pal_d;
      hscr_q      <= hscr_d;
      vscr_q      <= vscr_d;
      vrender_q   <= vrender_d;
      p_q         <= p_d;
      l_q         <= l_d;
      req_q       <= req_d;
      layer_q     <= layer_d;
      row_q       <= row_d;
      hpos_q      <= hpos_d;
      lpal_q      <= lpal_d;
      lprio_q     <= lprio_d;
      line_done_q <= line_done_d;
      overrun_q   <= overrun_d;
    end
  end

  assign req       = req_q;
  assign layer     = layer_q;
  assign row       = row_q;
  assign hpos      = hpos_q;
  assign lpal      = lpal_q;
  assign lprio     = lprio_q;
  assign busy      = (state_q != IDLE);
  assign line_done = line_done_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_jtshouse_scr_sched.sv
// Directed bench for jtshouse_scr_sched (HOFFSET=9, VOFFSET=0); flip cases are
// built only when JTSHOUSE_SCHED_FLIP_EN is defined.
module tb_jtshouse_scr_sched;

  logic        clk = 1'b0;
  logic        rst, hs, ack;
  logic [8:0]  vrender;
  logic [63:0] hscr, vscr;
  logic [5:0]  enb;
  logic [17:0] prio, pal;
`ifdef JTSHOUSE_SCHED_FLIP_EN
  logic        flip;
`endif
  logic        req, busy, line_done, overrun;
  logic [2:0]  layer, lpal, lprio;
  logic [8:0]  row, hpos;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  jtshouse_scr_sched #(.HOFFSET(9'd9), .VOFFSET(9'd0)) dut (
    .clk(clk), .rst(rst), .hs(hs), .vrender(vrender), .hscr(hscr), .vscr(vscr),
    .enb(enb), .prio(prio), .pal(pal),
`ifdef JTSHOUSE_SCHED_FLIP_EN
    .flip(flip),
`endif
    .req(req), .ack(ack), .layer(layer), .row(row), .hpos(hpos), .lpal(lpal),
    .lprio(lprio), .busy(busy), .line_done(line_done), .overrun(overrun)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_hs();
    hs = 1'b1;
    tick();
    hs = 1'b0;
  endtask

  function automatic logic [17:0] pack6(input logic [2:0] a0, a1, a2, a3, a4, a5);
    return {a5, a4, a3, a2, a1, a0};
  endfunction

  // Waits for a request, checks its fields, holds it for 'hold' cycles, then acks.
  task automatic serve(input string tag, input logic [2:0] el, ep, epal,
                       input logic [8:0] erow, ehpos, input int hold, input bit mutate);
    int  n = 0;
    bit  saw_done = 1'b0;
    bit  stable = 1'b1;
    while (!req && n < 100) begin
      if (line_done) saw_done = 1'b1;
      tick();
      n++;
    end
    chk({tag, "_req"}, 32'(req), 32'd1);
    chk({tag, "_nodone"}, 32'(saw_done), 32'd0);
    chk({tag, "_layer"}, 32'(layer), 32'(el));
    chk({tag, "_lprio"}, 32'(lprio), 32'(ep));
    chk({tag, "_lpal"}, 32'(lpal), 32'(epal));
    chk({tag, "_row"}, 32'(row), 32'(erow));
    chk({tag, "_hpos"}, 32'(hpos), 32'(ehpos));
    if (mutate) begin
      enb  = 6'b000001;
      prio = '0;
      pal  = '0;
    end
    for (int i = 0; i < hold; i++) begin
      tick();
      if (!req || layer !== el || lprio !== ep || row !== erow || hpos !== ehpos)
        stable = 1'b0;
    end
    chk({tag, "_hold"}, 32'(stable), 32'd1);
    ack = 1'b1;
    tick();
    ack = 1'b0;
    chk({tag, "_ackdrop"}, 32'(req), 32'd0);
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    bit saw_req = 1'b0;
    while (!line_done && n < 100) begin
      if (req) saw_req = 1'b1;
      tick();
      n++;
    end
    chk({tag, "_done"}, 32'(line_done), 32'd1);
    chk({tag, "_noreq"}, 32'(saw_req), 32'd0);
    tick();
    chk({tag, "_donepulse"}, 32'(line_done), 32'd0);
    chk({tag, "_idle"}, 32'(busy), 32'd0);
  endtask

  initial begin
    automatic int seq_l[6]   = '{3, 1, 2, 0, 5, 4};
    automatic int seq_p[6]   = '{0, 1, 1, 3, 3, 7};
    automatic int seq_pal[6] = '{4, 6, 5, 7, 2, 3};
    automatic int seq_h[6]   = '{9, 9, 9, 9, 0, 0};
    bit ok;

    rst = 1'b1; hs = 1'b0; ack = 1'b0; vrender = '0; hscr = '0; vscr = '0;
    enb = '0; prio = '0; pal = '0;
`ifdef JTSHOUSE_SCHED_FLIP_EN
    flip = 1'b0;
`endif
    repeat (3) tick();
    chk("rst_req", 32'(req), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_outs", 32'({layer, row, hpos, lpal, lprio, line_done, overrun}), 32'd0);
    rst = 1'b0;
    tick();

    // Empty line: 48 silent slots, then line_done.
    pulse_hs();
    chk("empty_busy0", 32'(busy), 32'd1);
    ok = 1'b1;
    for (int i = 1; i < 48; i++) begin
      tick();
      if (!busy || line_done || req) ok = 1'b0;
    end
    chk("empty_walk", 32'(ok), 32'd1);
    tick();
    chk("empty_done", 32'(line_done), 32'd1);
    chk("empty_idle", 32'(busy), 32'd0);
    tick();
    chk("empty_donepulse", 32'(line_done), 32'd0);

    // Six layers, priority ordering with ties broken by layer index.
    enb = 6'b111111; vrender = 9'd10; hscr = '0; vscr = '0;
    prio = pack6(3'd3, 3'd1, 3'd1, 3'd0, 3'd7, 3'd3);
    pal  = pack6(3'd7, 3'd6, 3'd5, 3'd4, 3'd3, 3'd2);
    pulse_hs();
    for (int i = 0; i < 6; i++)
      serve($sformatf("order%0d", i), 3'(seq_l[i]), 3'(seq_p[i]), 3'(seq_pal[i]),
            9'd10, 9'(seq_h[i]), 2, (i == 0));
    wait_done("order");

    // Inputs changed mid-line take effect on the next line: L0 prio 0, req after N+1.
    pulse_hs();
    tick();
    chk("lat_req", 32'(req), 32'd1);
    serve("lat", 3'd0, 3'd0, 3'd0, 9'd10, 9'd9, 1, 1'b0);
    wait_done("lat");

    // Scroll arithmetic with wrap: 100+450 -> 38, 17+9 -> 26.
    enb = 6'b000010; prio = '0; vrender = 9'd100;
    pal = pack6(3'd0, 3'd5, 3'd0, 3'd0, 3'd3, 3'd0);
    vscr = 64'h0000_0000_A1C2_0000;
    hscr = 64'h0000_0000_7E11_0000;
    pulse_hs();
    serve("scroll", 3'd1, 3'd0, 3'd5, 9'd38, 9'd26, 5, 1'b0);
    wait_done("scroll");

    // New line while a request is pending: abort, overrun, restart from the top.
    enb = 6'b111111; vrender = 9'd10; hscr = '0; vscr = '0;
    prio = pack6(3'd3, 3'd1, 3'd1, 3'd0, 3'd7, 3'd3);
    pal  = pack6(3'd7, 3'd6, 3'd5, 3'd4, 3'd3, 3'd2);
    pulse_hs();
    serve("pre_abort", 3'd3, 3'd0, 3'd4, 9'd10, 9'd9, 1, 1'b0);
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      if (req) ok = 1'b1;
      else tick();
    end
    chk("abort_wait", 32'(ok), 32'd1);
    hs = 1'b1; ack = 1'b1;
    tick();
    hs = 1'b0; ack = 1'b0;
    chk("abort_req", 32'(req), 32'd0);
    chk("abort_overrun", 32'(overrun), 32'd1);
    chk("abort_busy", 32'(busy), 32'd1);
    chk("abort_nodone", 32'(line_done), 32'd0);
    tick();
    chk("abort_overpulse", 32'(overrun), 32'd0);
    for (int i = 0; i < 6; i++)
      serve($sformatf("restart%0d", i), 3'(seq_l[i]), 3'(seq_p[i]), 3'(seq_pal[i]),
            9'd10, 9'(seq_h[i]), 1, 1'b0);
    wait_done("restart");

    // Reset while a request is pending, then a fresh line.
    enb = 6'b000010; prio = '0; vrender = 9'd100;
    pal = pack6(3'd0, 3'd5, 3'd0, 3'd0, 3'd3, 3'd0);
    vscr = 64'h0000_0000_A1C2_0000;
    hscr = 64'h0000_0000_7E11_0000;
    pulse_hs();
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      if (req) ok = 1'b1;
      else tick();
    end
    chk("rstmid_wait", 32'(ok), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rstmid_req", 32'(req), 32'd0);
    chk("rstmid_busy", 32'(busy), 32'd0);
    chk("rstmid_outs", 32'({layer, row, hpos, lpal, lprio}), 32'd0);
    tick();
    pulse_hs();
    serve("fresh", 3'd1, 3'd0, 3'd5, 9'd38, 9'd26, 1, 1'b0);
    wait_done("fresh");

`ifdef JTSHOUSE_SCHED_FLIP_EN
    // Flipped line: row inverted, hpos negated, fixed layers included.
    enb = 6'b010010;
    flip = 1'b1;
    pulse_hs();
    flip = 1'b0;
    serve("flip_l1", 3'd1, 3'd0, 3'd5, 9'd473, 9'd486, 1, 1'b0);
    serve("flip_l4", 3'd4, 3'd0, 3'd3, 9'd411, 9'd0, 1, 1'b0);
    wait_done("flip");
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
